legv8_control_unit: RTL

- Multi-cycle LEGv8 control sequencer: the initiator side that drives the 40-bit ControlWord consumed by the LEGv8 test-system datapath.
- Fetches via the PC, decodes the latched instruction (IR_out) and emits per-state control words.
- Evaluates branch conditions from registered status flags.
- Halts on illegal opcodes.

---
 rtl/legv8_control_unit.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/legv8_control_unit.sv
// Multi-cycle LEGv8 control sequencer: fetch, decode IR_out, and drive the
// 40-bit ControlWord for the test-system datapath; halts on illegal opcodes.
module legv8_control_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] IR_out,
    input  logic [3:0]  sr_flags,
    input  logic        alu_zero,
    output logic [39:0] ControlWord,
    output logic [2:0]  state,
    output logic        illegal
);

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC0 = 3'd1,
        EXEC1 = 3'd2,
        HALT  = 3'd7
    } state_t;

    typedef struct packed {
        logic [2:0] cgs;
        logic [2:0] ns;
        logic       as_sel;
        logic [1:0] ds;
        logic [1:0] ps;
        logic       pc_sel;
        logic       b_sel;
        logic       il;
        logic       sl;
        logic [4:0] fs;
        logic       c0;
        logic [1:0] size;
        logic       mw;
        logic       rw;
        logic [4:0] da;
        logic [4:0] sa;
        logic [4:0] sb;
    } cw_t;

    localparam logic [4:0] FS_AND   = 5'b00000;
    localparam logic [4:0] FS_OR    = 5'b00100;
    localparam logic [4:0] FS_ADD   = 5'b01000;
    localparam logic [4:0] FS_SUB   = 5'b01001;
    localparam logic [4:0] FS_XOR   = 5'b01100;
    localparam logic [4:0] FS_PASSB = 5'b10100;

    localparam logic [2:0] CGS_IMM12  = 3'b001;
    localparam logic [2:0] CGS_DADDR  = 3'b010;
    localparam logic [2:0] CGS_BR26   = 3'b011;
    localparam logic [2:0] CGS_BR19   = 3'b100;
    localparam logic [2:0] CGS_MOVW   = 3'b101;

    localparam logic [1:0] PS_HOLD  = 2'b00;
    localparam logic [1:0] PS_INC4  = 2'b01;
    localparam logic [1:0] PS_CONST = 2'b10;

    localparam logic [1:0] DS_ALU = 2'b00;
    localparam logic [1:0] DS_REG = 2'b01;
    localparam logic [1:0] DS_MEM = 2'b11;

    localparam logic [1:0] SIZE_32 = 2'b10;
    localparam logic [1:0] SIZE_64 = 2'b11;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    state_t state_q;
    logic   cbz_zero;
    cw_t    cw;
    logic   cbz_op;
    logic   bad_op;

    logic [10:0] op11;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;

    assign op11 = IR_out[31:21];
    assign rd   = IR_out[4:0];
    assign rn   = IR_out[9:5];
    assign rm   = IR_out[20:16];

    // The immediate field in IR[15:10] is consumed by the datapath, not here.
    logic unused_ir;
    assign unused_ir = ^IR_out[15:10];

    // Flags arrive as {V,C,N,Z}; 111x is "always".
    function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
        logic v, c, n, z, base;
        v = f[3];
        c = f[2];
        n = f[1];
        z = f[0];
        case (cond[3:1])
            3'b000:  base = z;
            3'b001:  base = c;
            3'b010:  base = n;
            3'b011:  base = v;
            3'b100:  base = c & ~z;
            3'b101:  base = (n == v);
            3'b110:  base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return (cond[3:1] == 3'b111) ? 1'b1 : (base ^ cond[0]);
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        cw     = '0;
        cbz_op = 1'b0;
        bad_op = 1'b0;
        case (state_q)
            FETCH: begin
                cw.as_sel = 1'b1;
                cw.ds     = DS_MEM;
                cw.size   = SIZE_32;
                cw.il     = 1'b1;
                cw.ps     = PS_INC4;
                cw.ns     = EXEC0;
            end
            EXEC0: begin
                cw.ns = FETCH;
                if (op11 == OP_ADD || op11 == OP_SUB || op11 == OP_AND ||
                    op11 == OP_ORR || op11 == OP_EOR) begin
                    cw.da = rd;
                    cw.sa = rn;
                    cw.sb = rm;
                    cw.rw = 1'b1;
                    cw.ds = DS_ALU;
                    case (op11)
                        OP_ADD:  cw.fs = FS_ADD;
                        OP_SUB:  begin cw.fs = FS_SUB; cw.c0 = 1'b1; end
                        OP_AND:  cw.fs = FS_AND;
                        OP_ORR:  cw.fs = FS_OR;
                        default: cw.fs = FS_XOR;
                    endcase
                end else if (IR_out[31:22] == 10'b1001000100 ||
                             IR_out[31:22] == 10'b1101000100) begin
                    cw.da    = rd;
                    cw.sa    = rn;
                    cw.sb    = rm;
                    cw.rw    = 1'b1;
                    cw.b_sel = 1'b1;
                    cw.cgs   = CGS_IMM12;
                    if (IR_out[30]) begin
                        cw.fs = FS_SUB;
                        cw.c0 = 1'b1;
                    end else begin
                        cw.fs = FS_ADD;
                    end
                end else if (IR_out[31:23] == 9'b110100101) begin
                    cw.fs    = FS_PASSB;
                    cw.b_sel = 1'b1;
                    cw.cgs   = CGS_MOVW;
                    cw.da    = rd;
                    cw.rw    = 1'b1;
                end else if (op11 == OP_LDUR || op11 == OP_STUR) begin
                    cw.sa    = rn;
                    cw.b_sel = 1'b1;
                    cw.cgs   = CGS_DADDR;
                    cw.fs    = FS_ADD;
                    cw.size  = SIZE_64;
                    if (op11 == OP_LDUR) begin
                        cw.ds = DS_MEM;
                        cw.da = rd;
                        cw.rw = 1'b1;
                    end else begin
                        cw.sb = rd;
                        cw.ds = DS_REG;
                        cw.mw = 1'b1;
                    end
                end else if (IR_out[31:26] == 6'b000101) begin
                    cw.cgs = CGS_BR26;
                    cw.ps  = PS_CONST;
                end else if (IR_out[31:25] == 7'b1011010) begin
                    // Test Rt through the ALU now; the branch resolves next cycle.
                    cw.sb  = rd;
                    cw.fs  = FS_PASSB;
                    cw.ns  = EXEC1;
                    cbz_op = 1'b1;
                end else if (IR_out[31:24] == 8'b01010100 && !IR_out[4]) begin
                    if (cond_true(IR_out[3:0], sr_flags)) begin
                        cw.cgs = CGS_BR19;
                        cw.ps  = PS_CONST;
                    end else begin
                        cw.ps  = PS_HOLD;
                    end
                end else begin
                    cw.ns  = HALT;
                    bad_op = 1'b1;
                end
            end
            EXEC1: begin
                cw.cgs = CGS_BR19;
                cw.ps  = (cbz_zero ^ IR_out[24]) ? PS_CONST : PS_HOLD;
                cw.ns  = FETCH;
            end
            default: begin
                cw.ns = HALT;
            end
        endcase
    end

    // Reset forces the word to zero at once so an abandoned instruction never writes.
    assign ControlWord = reset ? cw : '0;
    assign state       = state_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= FETCH;
            cbz_zero <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state_q <= state_t'(cw.ns);
            if (cbz_op) cbz_zero <= alu_zero;
            if (bad_op) illegal  <= 1'b1;
        end
    end

endmodule
